// File: rtl/cache_fill_fsm_pkg.sv
// Shared types and constants for the cache refill controller.
// Block geometry is fixed by the cache's 3-bit word offset.
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam int          WORDS_PER_BLOCK   = 8;
  localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;
  localparam int          WORD_BYTES        = 2;

  // Offset is at most 14, so the sum never carries out of the block.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [2:0] idx);
    return base + 16'(int'(idx) * WORD_BYTES);
  endfunction

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// 4-bit word counter with async reset, synchronous clear and increment enable.
module fill_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= 4'd0;
    else if (clr)
      count <= 4'd0;
    else if (inc)
      count <= count + 4'd1;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-handling refill controller: issues 8 pipelined word reads and streams
// returned words into the data array, writing the tag with the last word.
//
// state | meaning
// IDLE  | no fill in progress; a miss is accepted at the next edge
// FILL  | issuing reads and absorbing returned words until the 8th arrives
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic [15:0] memory_data,
  input  logic        memory_data_valid,
  output logic        fsm_busy,
  output logic        mem_en,
  output logic [15:0] memory_address,
  output logic        write_data_array,
  output logic        write_tag_array,
  output logic [15:0] fill_address
);

  localparam logic [3:0] WORD_COUNT = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0] LAST_WORD  = 4'(WORDS_PER_BLOCK - 1);

  fill_state_e state, state_nxt;
  logic [15:0] base;
  logic [3:0]  issue_cnt, recv_cnt;
  logic        accept;
  logic        issue_inc;

  assign accept    = (state == IDLE) && miss_detected;
  assign issue_inc = (state == FILL) && (issue_cnt < WORD_COUNT);

  fill_counter u_issue_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (issue_inc),
    .count (issue_cnt)
  );

  fill_counter u_recv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (write_data_array),
    .count (recv_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      base <= 16'h0000;
    else if (accept)
      base <= miss_address & BLOCK_OFFSET_MASK;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (miss_detected)   state_nxt = FILL;
      FILL: if (write_tag_array) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fsm_busy         = (state == FILL);
    mem_en           = issue_inc;
    // Once all reads are issued the address parks on the last word.
    memory_address   = word_addr(base, issue_cnt[3] ? 3'd7 : issue_cnt[2:0]);
    write_data_array = (state == FILL) && memory_data_valid && (recv_cnt < WORD_COUNT);
    fill_address     = write_data_array ? word_addr(base, recv_cnt[2:0]) : 16'h0000;
    write_tag_array  = write_data_array && (recv_cnt == LAST_WORD);
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: a hand-computed vector table for the
// basic fill plus sequences for gapped returns, wrap, and reset mid-fill.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = 16'h0000;
  logic [15:0] memory_data = 16'h0000;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy, mem_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, fill_address;

  int n_tests = 0;
  int n_fail  = 0;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data       (memory_data),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array),
    .fill_address      (fill_address)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        miss;
    logic [15:0] maddr;
    logic        valid;
    logic [15:0] data;
    logic        busy;
    logic        men;
    logic [15:0] mem_a;
    logic        wda;
    logic        wta;
    logic [15:0] fill_a;
  } vec_t;

  vec_t vec [15];

  // Full fill with hand-derived expectations; gapped or back-to-back returns.
  task automatic fill_check(input logic [15:0] addr, input bit gapped, input string tag);
    logic [15:0] base;
    int cyc;
    int nrx;
    int ntag;
    base = addr & 16'hFFF0;
    miss_detected = 1'b1;
    miss_address  = addr;
    step();
    miss_detected = 1'b0;
    cyc  = 0;
    nrx  = 0;
    ntag = 0;
    while (nrx < 8 && cyc < 40) begin
      memory_data_valid = gapped ? (cyc % 2 == 0) : 1'b1;
      memory_data       = 16'hB000 + 16'(nrx);
      @(negedge clk);
      chk({tag, "_busy"}, 16'(fsm_busy), 16'h1);
      chk({tag, "_mem_en"}, 16'(mem_en), (cyc < 8) ? 16'h1 : 16'h0);
      if (cyc < 8) chk({tag, "_mem_addr"}, memory_address, base + 16'(2 * cyc));
      chk({tag, "_wda"}, 16'(write_data_array), 16'(memory_data_valid));
      chk({tag, "_wta"}, 16'(write_tag_array), (memory_data_valid && nrx == 7) ? 16'h1 : 16'h0);
      if (write_tag_array) ntag++;
      if (memory_data_valid) begin
        chk({tag, "_fill_addr"}, fill_address, base + 16'(2 * nrx));
        nrx++;
      end
      step();
      cyc++;
    end
    memory_data_valid = 1'b0;
    chk({tag, "_words"}, 16'(nrx), 16'd8);
    chk({tag, "_tag_pulses"}, 16'(ntag), 16'd1);
    @(negedge clk);
    chk({tag, "_busy_after"}, 16'(fsm_busy), 16'h0);
    step();
  endtask

  initial begin
    // Basic fill, 4-cycle latency; miss pulsed mid-fill and valid in IDLE are ignored.
    vec[0]  = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vec[1]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 1'b0, 16'h0000};
    vec[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1232, 1'b0, 1'b0, 16'h0000};
    vec[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000};
    vec[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b0, 1'b0, 16'h0000};
    vec[5]  = '{1'b0, 16'h0000, 1'b1, 16'h00A0, 1'b1, 1'b1, 16'h1238, 1'b1, 1'b0, 16'h1230};
    vec[6]  = '{1'b0, 16'h0000, 1'b1, 16'h00A1, 1'b1, 1'b1, 16'h123A, 1'b1, 1'b0, 16'h1232};
    vec[7]  = '{1'b1, 16'h5678, 1'b1, 16'h00A2, 1'b1, 1'b1, 16'h123C, 1'b1, 1'b0, 16'h1234};
    vec[8]  = '{1'b0, 16'h0000, 1'b1, 16'h00A3, 1'b1, 1'b1, 16'h123E, 1'b1, 1'b0, 16'h1236};
    vec[9]  = '{1'b0, 16'h0000, 1'b1, 16'h00A4, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1238};
    vec[10] = '{1'b0, 16'h0000, 1'b1, 16'h00A5, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h123A};
    vec[11] = '{1'b0, 16'h0000, 1'b1, 16'h00A6, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h123C};
    vec[12] = '{1'b1, 16'h9999, 1'b1, 16'h00A7, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h123E};
    vec[13] = '{1'b0, 16'h0000, 1'b1, 16'h00EE, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};
    vec[14] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000};

    // Reset held across clock edges.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_busy", 16'(fsm_busy), 16'h0);
      chk("rst_mem_en", 16'(mem_en), 16'h0);
      chk("rst_mem_addr", memory_address, 16'h0000);
      chk("rst_wda", 16'(write_data_array), 16'h0);
      chk("rst_wta", 16'(write_tag_array), 16'h0);
      chk("rst_fill_addr", fill_address, 16'h0000);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_busy", 16'(fsm_busy), 16'h0);
    end

    for (int i = 0; i < 15; i++) begin
      miss_detected     = vec[i].miss;
      miss_address      = vec[i].maddr;
      memory_data_valid = vec[i].valid;
      memory_data       = vec[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), 16'(fsm_busy), 16'(vec[i].busy));
      chk($sformatf("vec%0d_mem_en", i), 16'(mem_en), 16'(vec[i].men));
      if (vec[i].men) chk($sformatf("vec%0d_mem_addr", i), memory_address, vec[i].mem_a);
      chk($sformatf("vec%0d_wda", i), 16'(write_data_array), 16'(vec[i].wda));
      chk($sformatf("vec%0d_wta", i), 16'(write_tag_array), 16'(vec[i].wta));
      if (vec[i].wda) chk($sformatf("vec%0d_fill_addr", i), fill_address, vec[i].fill_a);
      step();
    end
    miss_detected     = 1'b0;
    memory_data_valid = 1'b0;

    fill_check(16'h2000, 1'b1, "gapped");
    fill_check(16'hFFFF, 1'b0, "wrap");

    // Reset after 3 words: immediate IDLE, no tag write.
    miss_detected = 1'b1;
    miss_address  = 16'h3000;
    step();
    miss_detected = 1'b0;
    for (int i = 0; i < 3; i++) begin
      memory_data_valid = 1'b1;
      @(negedge clk);
      chk("abort_wda", 16'(write_data_array), 16'h1);
      chk("abort_fill_addr", fill_address, 16'h3000 + 16'(2 * i));
      chk("abort_wta", 16'(write_tag_array), 16'h0);
      step();
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 16'(fsm_busy), 16'h0);
    chk("abort_mem_en", 16'(mem_en), 16'h0);
    chk("abort_mem_addr", memory_address, 16'h0000);
    chk("abort_wda_rst", 16'(write_data_array), 16'h0);
    chk("abort_wta_rst", 16'(write_tag_array), 16'h0);
    chk("abort_fill_addr_rst", fill_address, 16'h0000);
    @(negedge clk);
    memory_data_valid = 1'b0;
    rst = 1'b0;
    step();
    fill_check(16'h0040, 1'b0, "refill");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller that sits directly beside the 2-way set-associative cache and refills it from main memory. On a miss it requests the 8 words (16 bytes) of the missing block from a pipelined multi-cycle memory, streams each returned word into the cache data array, and writes the tag/meta entry once the last word arrives. While the fill is in progress it holds `fsm_busy` high so the pipeline stalls.

## Interface
- `WORDS_PER_BLOCK`, 8: words per cache block; fixed by the cache's 3-bit word offset.
- `clk`  in  1  single clock, rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `miss_detected`  in  1  cache reports a miss for `miss_address`.
- `miss_address`  in  16  byte address of the missing access.
- `memory_data`  in  16  word returned by memory.
- `memory_data_valid`  in  1  `memory_data` is valid this cycle.
- `fsm_busy`  out  1  fill in progress; stall request.
- `mem_en`  out  1  memory read request this cycle.
- `memory_address`  out  16  address of the current memory read request.
- `write_data_array`  out  1  write `memory_data` into the cache data array at `fill_address`.
- `write_tag_array`  out  1  write the tag/valid meta entry for the block.
- `fill_address`  out  16  cache address for the current data write.

## Operation
- Block base is `miss_address & 16'hFFF0`. It is latched on acceptance and held for the whole fill.
- Two states:
  - IDLE: `miss_detected` at a rising edge latches the base, clears both counters, and moves to FILL.
  - FILL: returns to IDLE on the edge that consumes the 8th valid word.
- Issue counter (4-bit, 0..8):
  - In FILL while the count is below 8: `mem_en`=1 and `memory_address` = base + 2·count; the count increments each cycle.
  - At 8: `mem_en`=0 and `memory_address` holds its last value.
- Receive counter (4-bit, 0..8):
  - In FILL, `memory_data_valid`=1 with the count below 8 means `write_data_array`=1 and `fill_address` = base + 2·count; the count increments.
  - `write_data_array` is combinational from `memory_data_valid`, so the cache writes in the same cycle the word is present.
- `write_tag_array`=1 combinationally in the cycle the 8th valid word is written (receive count = 7 and valid). It is high for exactly one cycle per fill.
- `fsm_busy`=1 exactly while the state is FILL.
- Address arithmetic is 16-bit. The offset never exceeds 14, so base + offset cannot carry. Block 0xFFF0 fetches 0xFFF0..0xFFFE.

## Timing
- Reset values: state IDLE, counters 0, base 0. Outputs `fsm_busy`=0, `mem_en`=0, `memory_address`=0, `write_data_array`=0, `write_tag_array`=0, `fill_address`=0.
- Miss accepted at edge T0:
  - Cycles T0..T0+7: `mem_en`=1 with addresses base, base+2, …, base+14.
  - Cycle T0+8 onward: `mem_en`=0.
- Data timing is driven purely by `memory_data_valid`. No latency is assumed, and gaps between valid cycles are allowed.
- Fill latency is the cycle of the 8th valid word plus 1. `fsm_busy` falls on the edge that ends the 8th-word cycle.
- Boundary conditions:
  - `miss_detected` while in FILL, including the final cycle, is ignored. The cache re-asserts it after the refill if the miss persists.
  - A new miss is accepted at the first edge with state IDLE, so there is at least one cycle of `fsm_busy`=0 between fills.
  - `memory_data_valid` in IDLE, or after 8 words received, is ignored: no writes, no counter change.
  - `rst` asserted mid-fill: immediate return to IDLE with all outputs at reset values. No tag write occurs, and the partial block stays invalid in the meta array.

## Structure
- Shared package holds:
  - the state type (IDLE, FILL);
  - `WORDS_PER_BLOCK` = 8;
  - `BLOCK_OFFSET_MASK` = 16'hFFF0;
  - `WORD_BYTES` = 2.
- One sub-module, `fill_counter`: a 4-bit counter with asynchronous reset, synchronous clear, and increment enable. It is instantiated twice, for the issue and receive counts.
- State register plus combinational output logic live in `cache_fill_fsm`.

## Test plan
- Reset: hold `rst`=1 and toggle `clk` → all outputs 0; release → stays IDLE with `fsm_busy`=0.
- Basic fill, 4-cycle memory latency:
  - `miss_address`=0x1234 → `mem_en` 8 cycles at addresses 0x1230..0x123E.
  - Valid words 0xA0..0xA7 → 8 `write_data_array` pulses, `fill_address` 0x1230..0x123E.
  - `write_tag_array` pulses once with the 8th word; `fsm_busy` falls the next edge.
- Gapped returns: `memory_data_valid` toggling 1/0 → still exactly 8 writes, `fill_address` in order, busy until the 8th word.
- Wrap boundary: `miss_address`=0xFFFF → addresses 0xFFF0..0xFFFE, no 0x0000 access.
- Ignored events:
  - `miss_detected` pulsed mid-fill → no restart and base unchanged.
  - Extra valid after the 8th word or in IDLE → no writes.
- Reset mid-fill: assert `rst` after 3 words → immediate IDLE, `write_tag_array` never asserted. A new miss to 0x0040 then fills 0x0040..0x004E normally.
